// File: rtl/ws2812_decoder.sv
// ws2812_decoder
//   Decodes a WS2812 single-wire data stream into 24-bit GRB pixel words.
//   Each high pulse is classified by width (> BIT_THRESH clocks = 1, else 0),
//   bits are assembled MSB-first, and every completed word is presented as
//   separate colour bytes together with its 0-based pixel index in the frame.
//   A low period of RESET_LOW clocks ends a frame (latch).
//
// Ports
//   CLK      in   system clock (12 MHz nominal)
//   RST      in   asynchronous active-high reset
//   DIN      in   WS2812 data line, asynchronous to CLK
//   o_red    out  [7:0] red byte of the last completed word
//   o_green  out  [7:0] green byte of the last completed word
//   o_blue   out  [7:0] blue byte of the last completed word
//   o_valid  out  one-cycle strobe: colour bytes and o_index are new
//   o_index  out  [7:0] pixel number within the frame, saturates at 255
//   o_latch  out  one-cycle strobe: latch (reset-low) period detected
//   o_error  out  one-cycle strobe: overlong high pulse or partial word at latch
//
// Handshake: all outputs are strobes with no backpressure. The consumer must
// take o_red/o_green/o_blue/o_index in the single cycle o_valid is high; those
// values then hold until the next o_valid.

module ws2812_decoder #(
  parameter int BIT_THRESH = 7,
  parameter int HIGH_MAX   = 24,
  parameter int RESET_LOW  = 600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DIN,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_valid,
  output logic [7:0] o_index,
  output logic       o_latch,
  output logic       o_error
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // Limits are compared against the value a counter holds in the cycle
  // before it would reach the named width, so the strobe registers on the
  // edge where the width is reached.
  localparam logic [9:0] THRESH_C   = 10'(BIT_THRESH);
  localparam logic [9:0] HIGH_LIM_C = 10'(HIGH_MAX - 1);
  localparam logic [9:0] LOW_LIM_C  = 10'(RESET_LOW - 1);

  // Synchroniser and edge detect
  logic sync_q;
  logic din_q;
  logic din_dly_q;
  logic rise;
  logic fall;

  assign rise = din_q & ~din_dly_q;
  assign fall = ~din_q & din_dly_q;

  // Decoder state
  logic [1:0]  state_q,    state_d;
  logic [9:0]  high_cnt_q, high_cnt_d;
  logic [9:0]  low_cnt_q,  low_cnt_d;
  logic [4:0]  bit_cnt_q,  bit_cnt_d;
  logic [23:0] shift_q,    shift_d;
  logic [7:0]  pix_cnt_q,  pix_cnt_d;
  logic [7:0]  red_q,      red_d;
  logic [7:0]  green_q,    green_d;
  logic [7:0]  blue_q,     blue_d;
  logic [7:0]  index_q,    index_d;
  logic        valid_q,    valid_d;
  logic        latch_q,    latch_d;
  logic        error_q,    error_d;
  logic        bit_val;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= 1'b0;
      din_q     <= 1'b0;
      din_dly_q <= 1'b0;
    end else begin
      sync_q    <= DIN;
      din_q     <= sync_q;
      din_dly_q <= din_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pix_cnt_d  = pix_cnt_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    index_d    = index_q;
    valid_d    = 1'b0;
    latch_d    = 1'b0;
    error_d    = 1'b0;
    bit_val    = 1'b0;

    case (state_q)
      // Wait for a full quiet period before trusting the line; no latch here.
      ST_SYNC: begin
        if (din_q) begin
          low_cnt_d = 10'd0;
        end else if (low_cnt_q >= LOW_LIM_C) begin
          low_cnt_d = 10'd0;
          state_d   = ST_IDLE;
        end else begin
          low_cnt_d = sat_inc10(low_cnt_q);
        end
      end

      ST_IDLE: begin
        if (rise) begin
          high_cnt_d = 10'd1;
          state_d    = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          bit_val   = (high_cnt_q > THRESH_C);
          shift_d   = {shift_q[22:0], bit_val};
          low_cnt_d = 10'd1;
          state_d   = ST_LOW;
          if (bit_cnt_q == 5'd23) begin
            green_d   = shift_d[23:16];
            red_d     = shift_d[15:8];
            blue_d    = shift_d[7:0];
            index_d   = pix_cnt_q;
            valid_d   = 1'b1;
            pix_cnt_d = (pix_cnt_q == 8'hFF) ? pix_cnt_q : pix_cnt_q + 8'd1;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (high_cnt_q >= HIGH_LIM_C) begin
          // Line stuck high: abandon the frame and resynchronise.
          error_d    = 1'b1;
          bit_cnt_d  = 5'd0;
          pix_cnt_d  = 8'd0;
          shift_d    = 24'd0;
          high_cnt_d = 10'd0;
          low_cnt_d  = 10'd0;
          state_d    = ST_SYNC;
        end else begin
          high_cnt_d = sat_inc10(high_cnt_q);
        end
      end

      ST_LOW: begin
        if (rise) begin
          high_cnt_d = 10'd1;
          low_cnt_d  = 10'd0;
          state_d    = ST_HIGH;
        end else if (low_cnt_q >= LOW_LIM_C) begin
          latch_d   = 1'b1;
          pix_cnt_d = 8'd0;
          low_cnt_d = 10'd0;
          state_d   = ST_IDLE;
          if (bit_cnt_q != 5'd0) begin
            // Partial word at latch is dropped.
            error_d   = 1'b1;
            bit_cnt_d = 5'd0;
            shift_d   = 24'd0;
          end
        end else begin
          low_cnt_d = sat_inc10(low_cnt_q);
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_SYNC;
      high_cnt_q <= 10'd0;
      low_cnt_q  <= 10'd0;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 24'd0;
      pix_cnt_q  <= 8'd0;
      red_q      <= 8'd0;
      green_q    <= 8'd0;
      blue_q     <= 8'd0;
      index_q    <= 8'd0;
      valid_q    <= 1'b0;
      latch_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pix_cnt_q  <= pix_cnt_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      latch_q    <= latch_d;
      error_q    <= error_d;
    end
  end

  assign o_red   = red_q;
  assign o_green = green_q;
  assign o_blue  = blue_q;
  assign o_index = index_q;
  assign o_valid = valid_q;
  assign o_latch = latch_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Bench for ws2812_decoder. DIN is driven 1 time unit after each rising edge,
// outputs are captured on the falling edge. Expected pixels, indices and
// strobe times come from a frame-level model of the WS2812 protocol.

module tb_ws2812_decoder;

  localparam int BIT_THRESH = 7;
  localparam int HIGH_MAX   = 24;
  localparam int RESET_LOW  = 600;

  // Clock / reset
  logic       CLK = 1'b0;
  logic       RST;
  logic       DIN;
  logic [7:0] o_red, o_green, o_blue, o_index;
  logic       o_valid, o_latch, o_error;

  always #5 CLK = ~CLK;

  ws2812_decoder #(
    .BIT_THRESH (BIT_THRESH),
    .HIGH_MAX   (HIGH_MAX),
    .RESET_LOW  (RESET_LOW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .o_red   (o_red),
    .o_green (o_green),
    .o_blue  (o_blue),
    .o_valid (o_valid),
    .o_index (o_index),
    .o_latch (o_latch),
    .o_error (o_error)
  );

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  // Observed events
  logic [23:0] obs_word_q[$];
  int          obs_idx_q[$];
  int          obs_edge_q[$];
  int          latch_q[$];
  int          err_q[$];
  int          coincide = 0;

  always @(negedge CLK) begin
    if (o_valid) begin
      obs_word_q.push_back({o_green, o_red, o_blue});
      obs_idx_q.push_back(int'(o_index));
      obs_edge_q.push_back(edge_n);
    end
    if (o_latch) latch_q.push_back(edge_n);
    if (o_error) err_q.push_back(edge_n);
    if (o_valid && o_latch) coincide++;
  end

  // Scoreboard / reference model
  logic [23:0] exp_q[$];
  int          exp_idx_q[$];
  int          exp_fall_q[$];
  int          frame_idx = 0;
  int          last_fall = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // mode 0: 10H/5L for 1, 5H/10L for 0; mode 1: random widths;
  // mode 2: widths exactly at the threshold (7 -> 0, 8 -> 1).
  task automatic send_bits(input logic [23:0] w, input int nbits, input int mode);
    logic b;
    int   hw;
    int   lw;
    for (int i = 0; i < nbits; i++) begin
      b = w[23-i];
      case (mode)
        0:       begin hw = b ? 10 : 5; lw = b ? 5 : 10; end
        1:       begin
                   hw = b ? int'($urandom_range(20, BIT_THRESH + 2))
                          : int'($urandom_range(BIT_THRESH - 1, 2));
                   lw = int'($urandom_range(12, 3));
                 end
        default: begin hw = b ? BIT_THRESH + 1 : BIT_THRESH; lw = 6; end
      endcase
      DIN = 1'b1;
      step(hw);
      DIN = 1'b0;
      last_fall = edge_n;
      step(lw);
    end
  endtask

  task automatic send_word(input logic [23:0] w, input int mode);
    send_bits(w, 24, mode);
    exp_q.push_back(w);
    exp_idx_q.push_back(frame_idx);
    exp_fall_q.push_back(last_fall);
    if (frame_idx < 255) frame_idx++;
  endtask

  task automatic quiet(input int n);
    DIN = 1'b0;
    step(n);
  endtask

  task automatic check_pixels(input string tag);
    logic [23:0] w, ow;
    int          ix, f, oi, oe;
    chk({tag, "_count"}, obs_word_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      w  = exp_q.pop_front();
      ix = exp_idx_q.pop_front();
      f  = exp_fall_q.pop_front();
      if (obs_word_q.size() > 0) begin
        ow = obs_word_q.pop_front();
        oi = obs_idx_q.pop_front();
        oe = obs_edge_q.pop_front();
        chk({tag, "_word"}, int'(ow), int'(w));
        chk({tag, "_index"}, oi, ix);
        chk({tag, "_latency"}, oe - f, 3);
      end
    end
    obs_word_q.delete();
    obs_idx_q.delete();
    obs_edge_q.delete();
  endtask

  task automatic check_latch(input string tag, input int n_exp, input int exp_edge);
    chk({tag, "_latch_count"}, latch_q.size(), n_exp);
    if (n_exp > 0 && latch_q.size() > 0) chk({tag, "_latch_edge"}, latch_q[0], exp_edge);
    latch_q.delete();
  endtask

  task automatic check_err(input string tag, input int n_exp, input int exp_edge);
    chk({tag, "_error_count"}, err_q.size(), n_exp);
    if (n_exp > 0 && err_q.size() > 0) chk({tag, "_error_edge"}, err_q[0], exp_edge);
    err_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_red"},   int'(o_red),   0);
    chk({tag, "_green"}, int'(o_green), 0);
    chk({tag, "_blue"},  int'(o_blue),  0);
    chk({tag, "_index"}, int'(o_index), 0);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_latch"}, int'(o_latch), 0);
    chk({tag, "_error"}, int'(o_error), 0);
  endtask

  initial begin
    int          f;
    int          r;
    logic [23:0] w;

    // Reset and sync: no latch is reported while synchronising.
    RST = 1'b1;
    DIN = 1'b0;
    step(5);
    check_zero("reset");
    RST = 1'b0;
    quiet(RESET_LOW + 5);
    check_latch("sync", 0, 0);
    check_err("sync", 0, 0);

    // Single pixel, fixed bit timing.
    send_word(24'hFF8001, 0);
    f = last_fall;
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("single");
    check_latch("single", 1, f + RESET_LOW + 2);
    check_err("single", 0, 0);
    chk("hold_green", int'(o_green), 'hFF);
    chk("hold_red",   int'(o_red),   'h80);
    chk("hold_blue",  int'(o_blue),  'h01);

    // Multi-pixel frame: 10 words, latch, 2 words, latch.
    for (int i = 0; i < 10; i++) begin
      w = 24'($urandom());
      send_word(w, 1);
    end
    f = last_fall;
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("frame_a");
    check_latch("frame_a", 1, f + RESET_LOW + 2);
    for (int i = 0; i < 2; i++) begin
      w = 24'($urandom());
      send_word(w, 1);
    end
    f = last_fall;
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("frame_b");
    check_latch("frame_b", 1, f + RESET_LOW + 2);
    check_err("frame", 0, 0);

    // Threshold edges.
    w = 24'($urandom());
    send_word(w, 2);
    send_word(24'hA5A55A, 2);
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("thresh");
    check_latch("thresh", 1, last_fall + RESET_LOW + 2);

    // Overlong high pulse; a word sent before a full quiet period is ignored.
    DIN = 1'b1;
    r = edge_n;
    step(30);
    quiet(20);
    w = 24'($urandom());
    send_bits(w, 24, 1);
    quiet(RESET_LOW + 10);
    check_pixels("err_long");
    check_err("err_long", 1, r + HIGH_MAX + 2);
    check_latch("err_long", 0, 0);
    frame_idx = 0;
    w = 24'($urandom());
    send_word(w, 1);
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("resync");
    check_latch("resync", 1, last_fall + RESET_LOW + 2);

    // Partial word at latch.
    w = 24'($urandom());
    send_bits(w, 12, 1);
    f = last_fall;
    quiet(RESET_LOW + 10);
    check_pixels("partial");
    check_latch("partial", 1, f + RESET_LOW + 2);
    check_err("partial", 1, f + RESET_LOW + 2);

    // Reset mid-word.
    w = 24'($urandom());
    send_bits(w, 13, 1);
    RST = 1'b1;
    step(3);
    check_zero("rst_mid");
    RST = 1'b0;
    frame_idx = 0;
    quiet(RESET_LOW + 5);
    send_word(24'h12C3E7, 0);
    quiet(RESET_LOW + 10);
    frame_idx = 0;
    check_pixels("after_rst");
    check_latch("after_rst", 1, last_fall + RESET_LOW + 2);
    check_err("after_rst", 0, 0);

    chk("valid_latch_overlap", coincide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_decoder.md
# ws2812_decoder

Receive-side counterpart of the NeoPixel pixel writer. It samples a WS2812 single-wire data line (`DIN`), classifies each high pulse as a 0 or 1 bit by width, and assembles 24-bit GRB words. It presents each word as separate red, green and blue bytes with a one-cycle strobe and a pixel index, and flags the latch (reset-low) period that ends a frame. It is used to loop the pixel writer's output back on a PMOD pin for self-test, and to emulate a strip on the bench.

## Interface

Parameters:
- `BIT_THRESH`, default 7: high width in clocks (12 MHz); width > `BIT_THRESH` decodes as 1, otherwise 0.
- `HIGH_MAX`, default 24: high width in clocks (2 µs); a high pulse reaching this width is an error.
- `RESET_LOW`, default 600: consecutive low clocks (50 µs) that constitute a latch.

Ports (clock and reset first):
- `CLK`  input  1  system clock, 12 MHz.
- `RST`  input  1  asynchronous, active-high reset.
- `DIN`  input  1  WS2812 data line, asynchronous to `CLK`.
- `o_red`  output  8  red byte of the last completed word.
- `o_green`  output  8  green byte of the last completed word.
- `o_blue`  output  8  blue byte of the last completed word.
- `o_valid`  output  1  one-cycle strobe: colour outputs and `o_index` are new.
- `o_index`  output  8  pixel number of the word, 0-based within the frame, saturating at 255.
- `o_latch`  output  1  one-cycle strobe: latch period detected.
- `o_error`  output  1  one-cycle strobe: overlong high pulse, or partial word at latch.

## Operation

- `DIN` passes through a 2-flop synchroniser (`din_q`); `din_d` is `din_q` delayed one clock.
  - Rise = `din_q & ~din_d`.
  - Fall = `~din_q & din_d`.
- Counters: `high_cnt` and `low_cnt` (10 bits each, saturating); `bit_cnt` (5 bits, 0..23); `shift` (24 bits); `pix_cnt` (8 bits).
- States:
  - **SYNC**: entered on reset and on error. Counts consecutive low cycles; any high clears `low_cnt`. When `low_cnt` reaches `RESET_LOW`, go to IDLE. No `o_latch` is issued from SYNC.
  - **IDLE**: on rise, go to HIGH with `high_cnt` = 1.
  - **HIGH**: `high_cnt` increments each high cycle.
    - If `high_cnt` reaches `HIGH_MAX`: pulse `o_error`, clear `bit_cnt`/`pix_cnt`, go to SYNC.
    - On fall: shift in bit `(high_cnt > BIT_THRESH)` MSB-first and go to LOW with `low_cnt` = 1.
    - If that was the 24th bit (`bit_cnt` = 23): register `shift[23:16]`→`o_green`, `[15:8]`→`o_red`, `[7:0]`→`o_blue`, `o_index` ← `pix_cnt`; pulse `o_valid`; `pix_cnt` increments (saturating at 255); `bit_cnt` ← 0. Otherwise `bit_cnt` increments.
  - **LOW**: `low_cnt` increments.
    - On rise: go to HIGH with `high_cnt` = 1.
    - When `low_cnt` reaches `RESET_LOW`: pulse `o_latch`; clear `pix_cnt`; go to IDLE. If `bit_cnt` ≠ 0 at that point, also pulse `o_error` and clear `bit_cnt`; the partial word is discarded.
- Long lows in IDLE do not generate further latches.
- Reset values: every output is 0; state SYNC; all counters and `shift` are 0.
- An asserted `RST` aborts any word in progress immediately. After release, decoding restarts only after a full `RESET_LOW` low period.

## Timing

- Latency from the `DIN` fall at the end of bit 24 to `o_valid` high is 3 `CLK` edges: 2 synchroniser edges plus 1 registered output.
- The colour bytes and `o_index` change only in the same cycle `o_valid` rises and hold until the next `o_valid`.
- `o_latch` rises `RESET_LOW` + 2 clocks after `DIN` falls (LOW is entered on the clock after the fall is detected).
- `o_error` and `o_latch` can assert in the same cycle (partial-word latch). `o_valid` never coincides with `o_latch`.
- Pulse-width decoding is accurate to ±1 clock because of the synchroniser.
- Widths exactly equal to `BIT_THRESH` decode as 0.
- There is no backpressure: the consumer must accept `o_valid` on the strobe cycle.

## Test plan

- **Reset and sync**: hold `RST` 5 clocks, `DIN`=0 for 600 clocks, then send bits → all outputs 0 throughout reset; no `o_latch` during sync; decoding starts afterwards.
- **Single pixel**: 24 bits of 0xFF8001 (GRB), '1' = 10H/5L, '0' = 5H/10L, then 600 low → `o_valid` once with green=0xFF, red=0x80, blue=0x01, index=0. `o_latch` follows 602 clocks after the last fall.
- **Multi-pixel frame**: 10 words back-to-back, a latch, then 2 more words → indices 0..9, then 0..1. Each `o_valid` occurs exactly 3 clocks after its 24th fall.
- **Threshold edges**: high widths 7 and 8 clocks → decode 0 and 1 respectively.
- **Errors**:
  - 30-clock high pulse → `o_error` at `high_cnt` = 24; no `o_valid`; resync is required.
  - 12 bits then a latch → `o_error` and `o_latch` in the same cycle, and no `o_valid`.
- **Reset mid-word**: assert `RST` after 13 bits → all outputs 0. After 600 low clocks, a full word decodes at index 0.
